dmem_responder: RTL and testbench
=================================

# dmem_responder

Data-memory responder for the five-stage MIPS core's memory-stage port: the slave end of the interface whose initiator drives `memwriteM`, `aluoutM` (address), `writedataM` and samples `readdataM`. It decodes each address into a word-addressed data RAM or a small MMIO window:
- an LED register
- a free-running cycle counter
- a halt/exit register
- a sticky error flag

It sits beside the core at SoC top level. Reads are combinational within the memory stage; writes commit at the clock edge.

## Interface
Parameters:
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two.
- `MMIO_BASE`, 32'hBFAF_0000: base of the 16-byte MMIO window.

Ports:
- `clk` in 1: single clock, rising edge.
- `rst` in 1: reset, synchronous, active-low.
- `memwriteM` in 1: write strobe from the core, memory stage.
- `aluoutM` in 32: byte address.
- `writedataM` in 32: write data.
- `readdataM` out 32: read data, combinational from `aluoutM`.
- `led` out 16: LED register.
- `halt` out 1: set by a write to the HALT register.
- `halt_code` out 32: data captured by the first HALT write.
- `err` out 1: sticky access-error flag.

## Operation
Address decode:
- RAM hit when `aluoutM < DEPTH_WORDS*4`. Index is `aluoutM[log2(DEPTH_WORDS)+1:2]`.
- MMIO hit when `aluoutM[31:4] == MMIO_BASE[31:4]`. Offset is `aluoutM[3:2]`.
- Anything else is unmapped.

MMIO map:
- +0x0 LED: RW. Write takes `writedataM[15:0]`. Read returns {16'b0, led}.
- +0x4 CYCLE: RO, 32-bit. Increments every cycle while `halt`==0, wraps 0xFFFF_FFFF→0, freezes once `halt`=1. Writes are ignored and do not set `err`.
- +0x8 HALT: first write sets `halt` and latches `halt_code`. Later writes are ignored until reset. Read returns `halt_code`.
- +0xC: reads 0; writes are ignored and set `err`.

Reads:
- Unmapped reads return 0.
- `addr[1:0]` is ignored on reads; there is no read strobe, so reads never set `err`.

Writes (`memwriteM`=1):
- Misaligned (`aluoutM[1:0]` != 0): suppressed, and `err` is set.
- Unmapped: suppressed, and `err` is set.
- `err` clears only on reset.

Reset:
- Resets `led`=0, CYCLE=0, `halt`=0, `halt_code`=0, `err`=0.
- RAM contents are not reset.
- Reset asserted in the same cycle as a write suppresses that write.

Writes continue to be accepted after `halt`. Only the counter freezes.

## Timing
- Read latency 0: `readdataM` is a combinational function of `aluoutM` and the current register/RAM state.
- Write latency 1: state updates at the rising edge where `memwriteM`=1.
- Same-cycle write and read to the same address return the OLD value. The new value is visible from the next cycle.
- CYCLE reads N in the N-th cycle after `rst` deasserts (first cycle reads 0).
- A HALT write at edge k makes `halt`=1 from k. CYCLE holds the value it had after edge k, and it does not increment on the HALT edge itself.

## Structure
- Shared package `dmem_pkg`:
  - `MMIO_BASE` default
  - offset constants `OFF_LED`=2'd0, `OFF_CYCLE`=2'd1, `OFF_HALT`=2'd2
  - region enum {REG_RAM, REG_MMIO, REG_NONE}
- One sub-module, `dmem_ram`: DEPTH_WORDS×32 array with asynchronous read and synchronous write enable.
- Decode, MMIO registers and read mux live in `dmem_responder`.

## Test plan
- RAM: write 0xDEADBEEF @0x0000_0010, then read 0x10 next cycle → 0xDEADBEEF. Same-cycle read during the write → old value.
- LED: write 0x1234_ABCD @BASE+0x0 → `led`=0xABCD. Read → 0x0000_ABCD.
- CYCLE: release reset, read BASE+0x4 at cycles 0, 5, 100 → 0, 5, 100. Write 0x55 there → unchanged, `err`=0.
- HALT:
  - Write 0x0000_0001 @BASE+0x8 → `halt`=1, `halt_code`=1, CYCLE frozen.
  - Second write of 0x2 → `halt_code` stays 1.
- Errors:
  - Write @0x0000_0012 (misaligned) → RAM unchanged, `err`=1.
  - Write @0x8000_0000 (unmapped) → `err` stays 1.
  - Read of 0x8000_0000 → 0.
- Reset mid-operation: with `led`=0xFFFF, `halt`=1, `err`=1, assert `rst`=0 for one edge together with a RAM write → all MMIO outputs 0, the RAM write does not commit, and earlier RAM data is retained.

Source files
------------

// File: rtl/dmem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : dmem_pkg
// Description : Shared constants and types for the data-memory responder.
// Revision    : 1.0 - initial release
// ============================================================================
package dmem_pkg;

    localparam logic [31:0] DEFAULT_MMIO_BASE = 32'hBFAF_0000;

    localparam logic [1:0] OFF_LED   = 2'd0;
    localparam logic [1:0] OFF_CYCLE = 2'd1;
    localparam logic [1:0] OFF_HALT  = 2'd2;

    typedef enum logic [1:0] {
        REG_RAM  = 2'd0,
        REG_MMIO = 2'd1,
        REG_NONE = 2'd2
    } region_e;

endpackage : dmem_pkg
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Memory-stage data port between the core and the responder.
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if;

    logic        memwriteM;
    logic [31:0] aluoutM;
    logic [31:0] writedataM;
    logic [31:0] readdataM;

    modport master (
        output memwriteM,
        output aluoutM,
        output writedataM,
        input  readdataM
    );

    modport slave (
        input  memwriteM,
        input  aluoutM,
        input  writedataM,
        output readdataM
    );

endinterface : dmem_responder_if
`default_nettype wire

// File: rtl/dmem_ram.sv
`default_nettype none
// ============================================================================
// Module      : dmem_ram
// Description : Word-addressed data RAM, asynchronous read, synchronous write.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_ram #(
    parameter int DEPTH_WORDS = 1024,
    parameter int AW          = $clog2(DEPTH_WORDS)
) (
    input  wire logic          clk,
    input  wire logic          we,
    input  wire logic [AW-1:0] addr,
    input  wire logic [31:0]   wdata,
    output logic      [31:0]   rdata
);

    logic [31:0] mem_q [DEPTH_WORDS];

    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdata;
        end
    end

    assign rdata = mem_q[addr];

endmodule : dmem_ram
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Decodes memory-stage accesses into data RAM or MMIO registers.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import dmem_pkg::*;
#(
    parameter int          DEPTH_WORDS = 1024,
    parameter logic [31:0] MMIO_BASE   = DEFAULT_MMIO_BASE
) (
    input  wire logic        clk,
    input  wire logic        rst,
    dmem_responder_if.slave  bus,
    output logic [15:0]      led,
    output logic             halt,
    output logic [31:0]      halt_code,
    output logic             err
);

    localparam int          AW        = $clog2(DEPTH_WORDS);
    localparam logic [32:0] RAM_BYTES = 33'(DEPTH_WORDS) << 2;

    region_e     region;
    logic [1:0]  offset;
    logic        aligned;
    logic        wr_ok;
    logic        ram_we;
    logic [31:0] ram_rdata;

    logic [15:0] led_q, led_d;
    logic [31:0] cycle_q, cycle_d;
    logic        halt_q, halt_d;
    logic [31:0] halt_code_q, halt_code_d;
    logic        err_q, err_d;

    always_comb begin
        region = REG_NONE;
        if ({1'b0, bus.aluoutM} < RAM_BYTES) begin
            region = REG_RAM;
        end else if (bus.aluoutM[31:4] == MMIO_BASE[31:4]) begin
            region = REG_MMIO;
        end
    end

    assign offset  = bus.aluoutM[3:2];
    assign aligned = (bus.aluoutM[1:0] == 2'b00);
    assign wr_ok   = bus.memwriteM && aligned;
    // rst is active-low: a write in a reset cycle must not reach the RAM.
    assign ram_we  = wr_ok && (region == REG_RAM) && rst;

    dmem_ram #(
        .DEPTH_WORDS (DEPTH_WORDS),
        .AW          (AW)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .addr  (bus.aluoutM[AW+1:2]),
        .wdata (bus.writedataM),
        .rdata (ram_rdata)
    );

    always_comb begin
        led_d       = led_q;
        halt_d      = halt_q;
        halt_code_d = halt_code_q;
        err_d       = err_q;
        cycle_d     = cycle_q;

        if (wr_ok && region == REG_MMIO && offset == OFF_LED) begin
            led_d = bus.writedataM[15:0];
        end
        if (wr_ok && region == REG_MMIO && offset == OFF_HALT && !halt_q) begin
            halt_d      = 1'b1;
            halt_code_d = bus.writedataM;
        end
        if (bus.memwriteM && (!aligned || region == REG_NONE ||
                              (region == REG_MMIO && offset == 2'd3))) begin
            err_d = 1'b1;
        end
        // The counter also skips the edge on which HALT is first written.
        if (!halt_q && !halt_d) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            led_q       <= 16'd0;
            cycle_q     <= 32'd0;
            halt_q      <= 1'b0;
            halt_code_q <= 32'd0;
            err_q       <= 1'b0;
        end else begin
            led_q       <= led_d;
            cycle_q     <= cycle_d;
            halt_q      <= halt_d;
            halt_code_q <= halt_code_d;
            err_q       <= err_d;
        end
    end

    always_comb begin
        bus.readdataM = 32'd0;
        if (region == REG_RAM) begin
            bus.readdataM = ram_rdata;
        end else if (region == REG_MMIO) begin
            case (offset)
                OFF_LED:   bus.readdataM = {16'd0, led_q};
                OFF_CYCLE: bus.readdataM = cycle_q;
                OFF_HALT:  bus.readdataM = halt_code_q;
                default:   bus.readdataM = 32'd0;
            endcase
        end
    end

    assign led       = led_q;
    assign halt      = halt_q;
    assign halt_code = halt_code_q;
    assign err       = err_q;

endmodule : dmem_responder
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;

    localparam logic [31:0] BASE = 32'hBFAF_0000;

    logic        clk;
    logic        rst;
    logic [15:0] led;
    logic        halt;
    logic [31:0] halt_code;
    logic        err;

    int checks;
    int errors;

    dmem_responder_if bus ();

    dmem_responder #(
        .DEPTH_WORDS (1024),
        .MMIO_BASE   (BASE)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .bus       (bus),
        .led       (led),
        .halt      (halt),
        .halt_code (halt_code),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: time limit reached, required finish");
        $fatal(1);
    end

    // All stimulus changes happen on the falling edge; writes commit at the next rising edge.
    task automatic write_word(input logic [31:0] addr, input logic [31:0] data);
        bus.memwriteM  = 1'b1;
        bus.aluoutM    = addr;
        bus.writedataM = data;
        @(negedge clk);
        bus.memwriteM  = 1'b0;
    endtask

    task automatic wait_cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b0;
        bus.memwriteM  = 1'b0;
        bus.aluoutM    = 32'd0;
        bus.writedataM = 32'd0;
        wait_cycles(3);
        rst = 1'b1;
        #1;
        checks++;
        if ({led, halt, halt_code, err} !== 49'd0) begin
            errors++;
            $display("FAIL reset_outputs: got led=%h halt=%b code=%h err=%b, required all zero",
                     led, halt, halt_code, err);
        end
    endtask

    task automatic test_cycle();
        logic [31:0] v;
        bus.aluoutM = BASE + 32'h4;
        #1;
        checks++;
        if (bus.readdataM !== 32'd0) begin
            errors++;
            $display("FAIL cycle_0: got %h, required 00000000", bus.readdataM);
        end
        wait_cycles(5);
        #1;
        checks++;
        if (bus.readdataM !== 32'd5) begin
            errors++;
            $display("FAIL cycle_5: got %h, required 00000005", bus.readdataM);
        end
        wait_cycles(95);
        #1;
        checks++;
        if (bus.readdataM !== 32'd100) begin
            errors++;
            $display("FAIL cycle_100: got %h, required 00000064", bus.readdataM);
        end
        @(negedge clk);
        v = 32'd101;
        write_word(BASE + 32'h4, 32'h55);
        #1;
        checks++;
        if (bus.readdataM !== v + 32'd1 || err !== 1'b0) begin
            errors++;
            $display("FAIL cycle_write_ignored: got %h err=%b, required %h err=0",
                     bus.readdataM, err, v + 32'd1);
        end
    endtask

    task automatic test_ram();
        @(negedge clk);
        write_word(32'h10, 32'h1111_1111);
        bus.memwriteM  = 1'b1;
        bus.aluoutM    = 32'h10;
        bus.writedataM = 32'hDEAD_BEEF;
        #1;
        checks++;
        if (bus.readdataM !== 32'h1111_1111) begin
            errors++;
            $display("FAIL ram_same_cycle_old: got %h, required 11111111", bus.readdataM);
        end
        @(negedge clk);
        bus.memwriteM = 1'b0;
        #1;
        checks++;
        if (bus.readdataM !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_readback: got %h, required deadbeef", bus.readdataM);
        end
        @(negedge clk);
        write_word(32'hFFC, 32'hA5A5_5A5A);
        bus.aluoutM = 32'hFFF;
        #1;
        checks++;
        if (bus.readdataM !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL ram_last_word: got %h, required a5a55a5a", bus.readdataM);
        end
        bus.aluoutM = 32'h10;
        #1;
        checks++;
        if (bus.readdataM !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL ram_other_word: got %h, required deadbeef", bus.readdataM);
        end
    endtask

    task automatic test_led();
        @(negedge clk);
        write_word(BASE, 32'h1234_ABCD);
        bus.aluoutM = BASE + 32'h1;
        #1;
        checks++;
        if (led !== 16'hABCD || bus.readdataM !== 32'h0000_ABCD) begin
            errors++;
            $display("FAIL led_write: got led=%h read=%h, required led=abcd read=0000abcd",
                     led, bus.readdataM);
        end
    endtask

    task automatic test_halt();
        logic [31:0] c;
        @(negedge clk);
        bus.aluoutM = BASE + 32'h4;
        #1;
        c = bus.readdataM;
        @(negedge clk);
        c = c + 32'd1;
        write_word(BASE + 32'h8, 32'h1);
        bus.aluoutM = BASE + 32'h4;
        #1;
        checks++;
        if (halt !== 1'b1 || halt_code !== 32'h1 || bus.readdataM !== c) begin
            errors++;
            $display("FAIL halt_set: got halt=%b code=%h cycle=%h, required halt=1 code=1 cycle=%h",
                     halt, halt_code, bus.readdataM, c);
        end
        wait_cycles(4);
        #1;
        checks++;
        if (bus.readdataM !== c) begin
            errors++;
            $display("FAIL cycle_frozen: got %h, required %h", bus.readdataM, c);
        end
        @(negedge clk);
        write_word(BASE + 32'h8, 32'h2);
        bus.aluoutM = BASE + 32'h8;
        #1;
        checks++;
        if (halt_code !== 32'h1 || bus.readdataM !== 32'h1) begin
            errors++;
            $display("FAIL halt_second_write: got code=%h read=%h, required 1", halt_code, bus.readdataM);
        end
        @(negedge clk);
        write_word(BASE, 32'h0000_FFFF);
        checks++;
        if (led !== 16'hFFFF) begin
            errors++;
            $display("FAIL led_after_halt: got %h, required ffff", led);
        end
    endtask

    task automatic test_errors();
        checks++;
        if (err !== 1'b0) begin
            errors++;
            $display("FAIL err_clean: got %b, required 0", err);
        end
        write_word(32'h12, 32'hCAFE_F00D);
        bus.aluoutM = 32'h10;
        #1;
        checks++;
        if (err !== 1'b1 || bus.readdataM !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL misaligned_write: got err=%b ram=%h, required err=1 ram=deadbeef",
                     err, bus.readdataM);
        end
        @(negedge clk);
        write_word(32'h8000_0000, 32'h1);
        bus.aluoutM = 32'h8000_0000;
        #1;
        checks++;
        if (err !== 1'b1 || bus.readdataM !== 32'd0) begin
            errors++;
            $display("FAIL unmapped_access: got err=%b read=%h, required err=1 read=0",
                     err, bus.readdataM);
        end
        bus.aluoutM = 32'h1000;
        #1;
        checks++;
        if (bus.readdataM !== 32'd0) begin
            errors++;
            $display("FAIL ram_boundary_read: got %h, required 0", bus.readdataM);
        end
        bus.aluoutM = BASE + 32'hC;
        #1;
        checks++;
        if (bus.readdataM !== 32'd0) begin
            errors++;
            $display("FAIL reserved_read: got %h, required 0", bus.readdataM);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        rst            = 1'b0;
        bus.memwriteM  = 1'b1;
        bus.aluoutM    = 32'h10;
        bus.writedataM = 32'h0BAD_F00D;
        @(negedge clk);
        rst           = 1'b1;
        bus.memwriteM = 1'b0;
        #1;
        checks++;
        if ({led, halt, halt_code, err} !== 49'd0) begin
            errors++;
            $display("FAIL reset_mid_outputs: got led=%h halt=%b code=%h err=%b, required all zero",
                     led, halt, halt_code, err);
        end
        checks++;
        if (bus.readdataM !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL reset_mid_ram: got %h, required deadbeef", bus.readdataM);
        end
        bus.aluoutM = 32'hFFC;
        #1;
        checks++;
        if (bus.readdataM !== 32'hA5A5_5A5A) begin
            errors++;
            $display("FAIL reset_mid_retain: got %h, required a5a55a5a", bus.readdataM);
        end
        bus.aluoutM = BASE + 32'h4;
        #1;
        checks++;
        if (bus.readdataM !== 32'd0) begin
            errors++;
            $display("FAIL reset_mid_cycle: got %h, required 0", bus.readdataM);
        end
    endtask

    task automatic test_reserved_write();
        @(negedge clk);
        write_word(BASE + 32'hC, 32'h1234);
        checks++;
        if (err !== 1'b1 || led !== 16'd0 || halt !== 1'b0) begin
            errors++;
            $display("FAIL reserved_write: got err=%b led=%h halt=%b, required err=1 led=0 halt=0",
                     err, led, halt);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        test_reset();
        test_cycle();
        test_ram();
        test_led();
        test_errors();
        test_halt();
        test_reset_mid();
        test_reserved_write();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule : tb_dmem_responder
`default_nettype wire
